// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor.
// One BCD digit is processed per clock, least significant digit first.
// Subtraction adds the 9's complement of B with an initial carry of 1; a
// final carry of 0 means the raw result is the 10's complement of a negative
// difference, which the FIX pass converts back into a magnitude.
//
// Handshake: start is sampled on a rising edge only while the block is idle
// (IDLE or DONE); at that edge a, b and op are captured and may change freely
// afterwards. busy is high while the operation runs, done pulses for exactly
// one cycle when result/neg/overflow/invalid become valid, and those outputs
// hold until the next accepted start. start while busy is dropped.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  overflow,
  output logic                  invalid,
  output logic [1:0]            o_dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_op;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_result;
  logic            r_neg;
  logic            r_ovf;
  logic            r_inv;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_nx;
  logic [W-1:0]    w_a_nx;
  logic [W-1:0]    w_b_nx;
  logic            w_op_nx;
  logic            w_carry_nx;
  logic [IW-1:0]   w_idx_nx;
  logic [W-1:0]    w_result_nx;
  logic            w_neg_nx;
  logic            w_ovf_nx;
  logic            w_inv_nx;

  logic            w_bad;
  logic            w_last;
  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_r_dig;
  logic [3:0]      w_bx_dig;
  logic [4:0]      w_sum;
  logic            w_big;
  logic [3:0]      w_dig;

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign neg         = r_neg;
  assign overflow    = r_ovf;
  assign invalid     = r_inv;
  assign o_dbg_state = r_state;

  assign w_last = (r_idx == IW'(DIGITS - 1));

  // Flag any captured operand digit that is not a legal BCD digit.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // Single-digit BCD adder shared by the RUN and FIX passes.
  always_comb begin
    w_a_dig  = r_a[4*int'(r_idx) +: 4];
    w_b_dig  = r_b[4*int'(r_idx) +: 4];
    w_r_dig  = r_result[4*int'(r_idx) +: 4];
    w_bx_dig = r_op ? (4'd9 - w_b_dig) : w_b_dig;
    if (r_state == S_FIX) begin
      w_sum = {1'b0, 4'd9 - w_r_dig} + {4'd0, r_carry};
    end else begin
      w_sum = {1'b0, w_a_dig} + {1'b0, w_bx_dig} + {4'd0, r_carry};
    end
    w_big = (w_sum > 5'd9);
    w_dig = w_big ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
  end

  // Next-state and next-datapath logic for the digit-serial FSM.
  always_comb begin
    w_state_nx  = r_state;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_op_nx     = r_op;
    w_carry_nx  = r_carry;
    w_idx_nx    = r_idx;
    w_result_nx = r_result;
    w_neg_nx    = r_neg;
    w_ovf_nx    = r_ovf;
    w_inv_nx    = r_inv;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nx = S_IDLE;
        if (start) begin
          w_a_nx      = a;
          w_b_nx      = b;
          w_op_nx     = op;
          w_result_nx = '0;
          w_neg_nx    = 1'b0;
          w_ovf_nx    = 1'b0;
          w_inv_nx    = 1'b0;
          w_idx_nx    = '0;
          w_carry_nx  = op;
          w_state_nx  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_bad) begin
          // Non-BCD input: report and finish without doing any arithmetic.
          w_inv_nx    = 1'b1;
          w_result_nx = '0;
          w_state_nx  = S_DONE;
        end else begin
          w_result_nx[4*int'(r_idx) +: 4] = w_dig;
          w_carry_nx = w_big;
          if (w_last) begin
            if (!r_op) begin
              w_ovf_nx   = w_big;
              w_state_nx = S_DONE;
            end else if (w_big) begin
              w_neg_nx   = 1'b0;
              w_state_nx = S_DONE;
            end else begin
              // Negative difference: recomplement the raw result.
              w_neg_nx   = 1'b1;
              w_idx_nx   = '0;
              w_carry_nx = 1'b1;
              w_state_nx = S_FIX;
            end
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end
      end
      S_FIX: begin
        w_result_nx[4*int'(r_idx) +: 4] = w_dig;
        w_carry_nx = w_big;
        if (w_last) begin
          w_state_nx = S_DONE;
        end else begin
          w_idx_nx = r_idx + IW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_op     <= w_op_nx;
      r_carry  <= w_carry_nx;
      r_idx    <= w_idx_nx;
      r_result <= w_result_nx;
      r_neg    <= w_neg_nx;
      r_ovf    <= w_ovf_nx;
      r_inv    <= w_inv_nx;
      r_busy   <= (w_state_nx == S_RUN) || (w_state_nx == S_FIX);
      r_done   <= (w_state_nx == S_DONE);
    end
  end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 The block SHALL have one parameter: DIGITS, default 4, number of packed BCD digits per operand (DIGITS >= 1).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-006 The block SHALL have port a, input, 4*DIGITS bits: operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 The block SHALL have port b, input, 4*DIGITS bits: operand B, packed BCD.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 4*DIGITS bits: packed BCD magnitude.
REQ-011 The block SHALL have port neg, output, 1 bit: subtraction result negative.
REQ-012 The block SHALL have port overflow, output, 1 bit: addition carry out of the top digit.
REQ-013 The block SHALL have port invalid, output, 1 bit: some captured input digit was > 9.

Function
REQ-014 States SHALL be IDLE, RUN, FIX, DONE; all outputs SHALL be registered.
REQ-015 start SHALL be accepted only in IDLE or DONE. At accepting edge k the block SHALL capture a, b, op; clear result, neg, overflow, invalid; load digit index 0; load carry = op.
REQ-016 If any captured digit of a or b exceeds 9: state -> DONE at edge k+1; invalid = 1; result = 0; no arithmetic performed.
REQ-017 Otherwise state -> RUN at edge k. One digit per cycle, LSD first: digit i SHALL be written at edge k+1+i.
REQ-018 Per-digit rule in RUN: b' = b_i when op = 0, else 9 - b_i (9's complement); s = a_i + b' + carry (5-bit). If s > 9, digit = (s + 6) mod 16 and carry = 1; otherwise digit = s and carry = 0.
REQ-019 After digit DIGITS-1 (edge k+DIGITS):
  - op = 0: overflow = carry; -> DONE.
  - op = 1, carry = 1: neg = 0; -> DONE.
  - op = 1, carry = 0: neg = 1; -> FIX with digit index 0, carry = 1.
REQ-020 FIX SHALL rewrite each result digit, LSD first, one per cycle: s = (9 - r_i) + carry, with the same >9 correction as RUN. This yields magnitude 10^DIGITS - raw. State -> DONE at edge k+2*DIGITS.
REQ-021 done SHALL be 1 exactly while in DONE, which lasts one cycle. DONE -> IDLE, or -> new operation if start is accepted in DONE.
REQ-022 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-023 start while busy SHALL be ignored with no effect.
REQ-024 result, neg, overflow, invalid SHALL hold their values from DONE until the next accepted start.
REQ-025 Changes on a, b, op after capture SHALL NOT affect the operation in progress.
REQ-026 Latency from the accepting edge to done high:
  - invalid: 1 cycle
  - add, or sub with nonnegative result: DIGITS cycles
  - sub with negative result: 2*DIGITS cycles
REQ-027 Subtraction SHALL never assert overflow. Equal operands SHALL give result 0 with neg = 0.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force: state IDLE; busy, done, neg, overflow, invalid = 0; result = 0; carry and digit index = 0.
REQ-029 Reset asserted mid-RUN or mid-FIX SHALL abort the operation without asserting done. After rst_n rises, the first start SHALL be accepted normally.

Verification (DIGITS = 4)
REQ-030 op=0, a=0x1234, b=0x5678 -> result 0x6912, overflow 0, neg 0; done 4 cycles after the accepting edge; busy high for 4 cycles.
REQ-031 op=0, a=0x9999, b=0x0001 -> result 0x0000, overflow 1.
REQ-032 op=1, a=0x5000, b=0x1234 -> result 0x3766, neg 0, done after 4 cycles. Then op=1, a=b=0x0777 -> result 0x0000, neg 0.
REQ-033 op=1, a=0x0123, b=0x0456 -> result 0x0333, neg 1, overflow 0; done after 8 cycles; busy high for 8 cycles.
REQ-034 a=0x12A4, b=0x0001 -> invalid 1, result 0x0000, done after 1 cycle. A start pulsed during busy of a valid operation -> ignored, and the original result is unchanged.
REQ-035 rst_n low 2 cycles after starting 0x1234+0x5678 -> all outputs 0 and no done. After release, start 0x0001+0x0002 -> result 0x0003 after 4 cycles.
